// File: rtl/soc_pkg.sv
// Shared SoC definitions: halt monitor FSM encoding and RISC-V instruction
// encodings used to recognise program termination.
package soc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CONFIRM = 2'd2,
    HALTED  = 2'd3
  } halt_state_t;

  localparam logic [31:0] RV_JAL_X0_SELF = 32'h0000006F;
  localparam logic [31:0] RV_BUBBLE      = 32'h00000000;

  // Confirm counter width; covers the legal HALT_CONFIRM range 1..15.
  localparam int CONF_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load; clear beats load,
// load beats increment. Asynchronous active-low reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/halt_monitor.sv
// Program-termination observer: detects a jal x0,0 self-loop in fetch with a
// decode bubble, then freezes cycle/instret/stall counters and raises halted.
// Optional stall counter enabled by defining HALT_MONITOR_STALL_CNT_EN.
module halt_monitor
  import soc_pkg::*;
#(
  parameter int          CNT_WIDTH    = 32,
  parameter int          HALT_CONFIRM = 2,
  parameter logic [31:0] HALT_INSTR   = RV_JAL_X0_SELF,
  parameter logic [31:0] BUBBLE_INSTR = RV_BUBBLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 fetch_valid,
  input  logic [31:0]          fetch_instr,
  input  logic                 decode_valid,
  input  logic [31:0]          decode_instr,
  input  logic                 retire_valid,
  input  logic                 stall,
  output logic                 halted,
  output logic                 halt_pulse,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output halt_state_t          fsm_state
);

  localparam logic [CONF_W-1:0] CONF_TGT = CONF_W'(HALT_CONFIRM);

  halt_state_t          state_next;
  logic [CONF_W-1:0]    conf, conf_next;
  logic [CNT_WIDTH-1:0] snap, snap_next, cyc_p1;
  logic                 pattern;
  logic                 cyc_inc, cyc_load, active, halt_set;

  assign pattern = fetch_valid && (fetch_instr == HALT_INSTR) &&
                   (!decode_valid || (decode_instr == BUBBLE_INSTR));

  assign cyc_p1 = (cycle_count == '1) ? cycle_count : cycle_count + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_state  <= IDLE;
      conf       <= '0;
      snap       <= '0;
      halted     <= 1'b0;
      halt_pulse <= 1'b0;
    end else if (clear) begin
      fsm_state  <= IDLE;
      conf       <= '0;
      snap       <= '0;
      halted     <= 1'b0;
      halt_pulse <= 1'b0;
    end else begin
      fsm_state  <= state_next;
      conf       <= conf_next;
      snap       <= snap_next;
      halted     <= halted | halt_set;
      halt_pulse <= halt_set;
    end
  end

  always_comb begin
    state_next = fsm_state;
    conf_next  = conf;
    snap_next  = snap;
    cyc_inc    = 1'b0;
    cyc_load   = 1'b0;
    active     = 1'b0;
    halt_set   = 1'b0;
    case (fsm_state)
      // IDLE with a valid fetch behaves exactly like a RUN edge.
      IDLE, RUN: begin
        if (fsm_state == RUN || fetch_valid) begin
          state_next = RUN;
          cyc_inc    = 1'b1;
          active     = 1'b1;
          if (pattern) begin
            snap_next = cyc_p1;
            conf_next = CONF_W'(1);
            if (CONF_TGT == CONF_W'(1)) begin
              state_next = HALTED;
              halt_set   = 1'b1;
            end else begin
              state_next = CONFIRM;
            end
          end
        end
      end
      CONFIRM: begin
        cyc_inc = 1'b1;
        active  = 1'b1;
        if (pattern) begin
          conf_next = conf + CONF_W'(1);
          if (conf + CONF_W'(1) == CONF_TGT) begin
            state_next = HALTED;
            halt_set   = 1'b1;
            cyc_load   = 1'b1;
          end
        end else begin
          conf_next  = '0;
          state_next = RUN;
        end
      end
      default: ;
    endcase
  end

  // Entering HALTED from CONFIRM rewinds the cycle count to the first pattern cycle.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk      (clk),
    .rst      (rst),
    .inc      (cyc_inc),
    .clr      (clear),
    .load     (cyc_load),
    .load_val (snap),
    .count    (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_instret (
    .clk      (clk),
    .rst      (rst),
    .inc      (active && retire_valid),
    .clr      (clear),
    .load     (1'b0),
    .load_val ('0),
    .count    (instret_count)
  );

`ifdef HALT_MONITOR_STALL_CNT_EN
  logic stall_active;
  assign stall_active = stall && ((fsm_state == RUN) || (fsm_state == CONFIRM));

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (
    .clk      (clk),
    .rst      (rst),
    .inc      (stall_active),
    .clr      (clear),
    .load     (1'b0),
    .load_val ('0),
    .count    (stall_count)
  );
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_count  = '0;
`endif

endmodule
